vgacon_term_ctrl: RTL and testbench

VGACON_TERM_CTRL -- requirements
Module: vgacon_term_ctrl

---
 rtl/vgacon_term_ctrl_pkg.sv | 38 +++
 rtl/vgacon_term_ctrl.sv | 175 +++++++++++++++++
 tb/tb_vgacon_term_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vgacon_term_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vgacon_term_ctrl_pkg                                      |
// | Brief    : Shared types and constants for the text-console control   |
// |            FSM (geometry defaults, state enum, control codes).       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package vgacon_term_ctrl_pkg;

  // Default console geometry
  localparam int DEF_NUM_ROWS = 3;
  localparam int DEF_NUM_COLS = 10;

  // Controller states
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    EXEC        = 3'd1,
    SCROLL_COPY = 3'd2,
    SCROLL_CLR  = 3'd3,
    CLR_ALL     = 3'd4
  } state_t;

  // Control codes recognised in the byte stream
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  // A space in colour 0: what cleared cells are filled with
  localparam logic [8:0] BLANK_CELL = 9'h020;

  // Bytes that produce a glyph in the buffer
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vgacon_term_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vgacon_term_ctrl                                          |
// | Brief    : Byte-stream terminal controller for an external text      |
// |            buffer: prints glyphs, handles LF/CR/BS/FF, scrolls and   |
// |            clears; a host write port pre-empts controller writes.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module vgacon_term_ctrl
  import vgacon_term_ctrl_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int NUM_COLS = DEF_NUM_COLS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  input  logic [1:0] in_color,
  input  logic       host_we,
  input  logic [4:0] host_addr,
  input  logic [8:0] host_data,
  output logic       buf_we,
  output logic [4:0] buf_waddr,
  output logic [8:0] buf_wdata,
  output logic [4:0] buf_raddr,
  input  logic [8:0] buf_rdata,
  output logic [1:0] cur_row,
  output logic [3:0] cur_col,
  output logic       busy
);

  localparam logic [4:0] COLS5     = 5'(NUM_COLS);
  localparam logic [4:0] COPY_LAST = 5'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [4:0] CELL_LAST = 5'(NUM_ROWS * NUM_COLS - 1);
  localparam logic [1:0] ROW_LAST  = 2'(NUM_ROWS - 1);
  localparam logic [3:0] COL_LAST  = 4'(NUM_COLS - 1);

  state_t     state;
  logic [4:0] idx;
  logic [7:0] cmd_byte;
  logic [1:0] cmd_color;

  logic       printable;
  logic       wrap;
  logic       row_adv;
  logic [4:0] cur_addr;
  logic       ctrl_we;
  logic [4:0] ctrl_waddr;
  logic [8:0] ctrl_wdata;
  logic       stall;

  assign printable = is_printable(cmd_byte);
  assign wrap      = printable && (cur_col == COL_LAST);
  assign row_adv   = wrap || (cmd_byte == CH_LF);
  assign cur_addr  = 5'(cur_row) * COLS5 + 5'(cur_col);

  // Controller's own write request and scroll read address for this cycle
  always_comb begin
    ctrl_we    = 1'b0;
    ctrl_waddr = '0;
    ctrl_wdata = BLANK_CELL;
    buf_raddr  = '0;
    case (state)
      EXEC: begin
        if (printable) begin
          ctrl_we    = 1'b1;
          ctrl_waddr = cur_addr;
          ctrl_wdata = {cmd_color, cmd_byte[6:0]};
        end
      end
      SCROLL_COPY: begin
        ctrl_we    = 1'b1;
        ctrl_waddr = idx;
        buf_raddr  = idx + COLS5;
        ctrl_wdata = buf_rdata;
      end
      SCROLL_CLR, CLR_ALL: begin
        ctrl_we    = 1'b1;
        ctrl_waddr = idx;
      end
      default: ;
    endcase
  end

  // A host write owns the port; any controller write waits a cycle
  assign stall     = ctrl_we && host_we;
  assign buf_we    = host_we || ctrl_we;
  assign buf_waddr = host_we ? host_addr : ctrl_waddr;
  assign buf_wdata = host_we ? host_data : ctrl_wdata;
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

  // Main FSM: byte acceptance, cursor update, scroll and clear sweeps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_row   <= '0;
      cur_col   <= '0;
      idx       <= '0;
      cmd_byte  <= '0;
      cmd_color <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cmd_byte  <= in_byte;
            cmd_color <= in_color;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            state <= IDLE;
            if (printable) begin
              cur_col <= wrap ? '0 : cur_col + 4'd1;
            end else begin
              case (cmd_byte)
                CH_LF, CH_CR: cur_col <= '0;
                CH_BS: if (cur_col != '0) cur_col <= cur_col - 4'd1;
                CH_FF: begin
                  state <= CLR_ALL;
                  idx   <= '0;
                end
                default: ;
              endcase
            end
            // Advancing past the bottom row keeps the cursor there and scrolls
            if (row_adv) begin
              if (cur_row == ROW_LAST) begin
                state <= SCROLL_COPY;
                idx   <= '0;
              end else begin
                cur_row <= cur_row + 2'd1;
              end
            end
          end
        end
        SCROLL_COPY: begin
          // idx runs straight on into the last row for the clear phase
          if (!stall) begin
            idx <= idx + 5'd1;
            if (idx == COPY_LAST) state <= SCROLL_CLR;
          end
        end
        SCROLL_CLR: begin
          if (!stall) begin
            if (idx == CELL_LAST) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        CLR_ALL: begin
          if (!stall) begin
            if (idx == CELL_LAST) begin
              idx     <= '0;
              cur_row <= '0;
              cur_col <= '0;
              state   <= IDLE;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vgacon_term_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_vgacon_term_ctrl                                       |
// | Brief    : Self-checking bench for vgacon_term_ctrl with an external |
// |            buffer model and a console-level reference model.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_vgacon_term_ctrl;

  localparam int R = 3;
  localparam int C = 10;
  localparam int N = R * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_byte = '0;
  logic [1:0] in_color = '0;
  logic       host_we = 1'b0;
  logic [4:0] host_addr = '0;
  logic [8:0] host_data = '0;
  logic       buf_we;
  logic [4:0] buf_waddr;
  logic [8:0] buf_wdata;
  logic [4:0] buf_raddr;
  logic [8:0] buf_rdata;
  logic [1:0] cur_row;
  logic [3:0] cur_col;
  logic       busy;

  always #5 clk = ~clk;

  vgacon_term_ctrl #(.NUM_ROWS(R), .NUM_COLS(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_color(in_color),
    .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  // External text buffer: synchronous write, combinational read
  logic [8:0] mem [0:N-1];
  always @(posedge clk) if (buf_we && int'(buf_waddr) < N) mem[buf_waddr] <= buf_wdata;
  assign buf_rdata = (int'(buf_raddr) < N) ? mem[buf_raddr] : 9'h1FF;

  // Reference model: screen as a flat array plus a cursor
  logic [8:0] ref_mem [0:N-1];
  int mr, mc, exp_lat;
  int exp_wr[$];
  int got_wr[$];
  int last_a;
  logic [8:0] last_d;
  logic [8:0] hd [0:2];
  int errors = 0;
  int checks = 0;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Console behaviour for one byte: expected writes, latency, cursor, screen
  task automatic model_apply(input logic [7:0] b, input logic [1:0] col);
    bit adv = 0;
    exp_wr.delete();
    exp_lat = 2;
    if (b >= 8'h20 && b <= 8'h7E) begin
      ref_mem[mr*C + mc] = {col, b[6:0]};
      exp_wr.push_back(mr*C + mc);
      mc++;
      if (mc == C) begin mc = 0; adv = 1; end
    end else if (b == 8'h0A) begin
      mc = 0; adv = 1;
    end else if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h08) begin
      if (mc > 0) mc--;
    end else if (b == 8'h0C) begin
      for (int i = 0; i < N; i++) begin ref_mem[i] = 9'h020; exp_wr.push_back(i); end
      mr = 0; mc = 0; exp_lat = 2 + N;
    end
    if (adv) begin
      if (mr < R-1) mr++;
      else begin
        for (int i = 0; i < N-C; i++) ref_mem[i] = ref_mem[i+C];
        for (int i = N-C; i < N; i++) ref_mem[i] = 9'h020;
        for (int i = 0; i < N; i++) exp_wr.push_back(i);
        exp_lat = 2 + (N-C) + C;
      end
    end
  endtask

  // Present one byte; optionally hold a 3-cycle host write from cycle host_at
  task automatic send(input logic [7:0] b, input logic [1:0] col, input int host_at);
    got_wr.delete();
    last_a = -1; last_d = '0;
    @(negedge clk);
    in_valid = 1'b1; in_byte = b; in_color = col;
    #1 chk("ready_before", 32'(in_ready), 32'd1);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      if (host_at > 0 && cyc >= host_at && cyc < host_at + 3) begin
        host_we = 1'b1; host_addr = 5'(cyc - host_at); host_data = hd[cyc - host_at];
      end else host_we = 1'b0;
      #1;
      if (host_we) begin
        chk("host_waddr", 32'(buf_waddr), 32'(host_addr));
        chk("host_wdata", 32'(buf_wdata), 32'(host_data));
      end else if (buf_we && !in_ready) begin
        got_wr.push_back(int'(buf_waddr));
        last_a = int'(buf_waddr); last_d = buf_wdata;
      end
      if (host_at > 0 && cyc == host_at + 3) chk("resume_idx", 32'(buf_waddr), 32'd4);
      if (in_ready) begin
        chk("idle_we", 32'(buf_we), 32'd0);
        break;
      end
      if (cyc >= 200) begin chk("timeout", 32'd0, 32'd1); break; end
    end
    host_we = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    int bad = 0;
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_row"}, 32'(cur_row), 32'(mr));
    chk({tag, "_col"}, 32'(cur_col), 32'(mc));
    if (got_wr.size() != exp_wr.size()) bad++;
    else for (int i = 0; i < exp_wr.size(); i++) if (got_wr[i] != exp_wr[i]) bad++;
    chk({tag, "_wrseq"}, 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({tag, "_screen"}, 32'(bad), 32'd0);
  endtask

  task automatic step(input logic [7:0] b, input logic [1:0] col, input string tag);
    model_apply(b, col);
    send(b, col, 0);
    compare_all(tag);
  endtask

  logic [7:0] rb;
  logic [1:0] rc;
  int k;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(buf_we), 32'd0);
    chk("rst_row", 32'(cur_row), 32'd0);
    chk("rst_col", 32'(cur_col), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    mr = 0; mc = 0;
    #1 chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_we", 32'(buf_we), 32'd0);

    // Fill the buffer with random cells through the host port
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      host_we = 1'b1; host_addr = 5'(i); host_data = 9'($urandom);
      ref_mem[i] = host_data;
    end
    @(negedge clk) host_we = 1'b0;

    // 'A' in colour 2 at the home position
    step(8'h41, 2'd2, "char_A");
    chk("A_nwr", 32'(got_wr.size()), 32'd1);
    chk("A_addr", 32'(last_a), 32'd0);
    chk("A_data", 32'(last_d), 32'h141);
    chk("A_col", 32'(cur_col), 32'd1);

    // Complete row 0: last write at 9, wrap to (1,0), no scroll
    for (int i = 1; i < C; i++) step(8'($urandom_range(32, 126)), 2'($urandom), "row0");
    chk("row0_last_addr", 32'(last_a), 32'd9);
    chk("row0_row", 32'(cur_row), 32'd1);
    chk("row0_col", 32'(cur_col), 32'd0);
    chk("row0_lat", 32'(cyc), 32'd2);

    // Backspace at column 0 and a non-printing byte
    step(8'h08, 2'd1, "bs_col0");
    chk("bs_nwr", 32'(got_wr.size()), 32'd0);
    step(8'h07, 2'd1, "bel");
    chk("bel_nwr", 32'(got_wr.size()), 32'd0);
    chk("bel_lat", 32'(cyc), 32'd2);

    // Reach (2,5), then LF scrolls
    step(8'h0A, 2'd0, "lf_row1");
    for (int i = 0; i < 5; i++) step(8'($urandom_range(32, 126)), 2'($urandom), "row2");
    chk("pre_scroll_col", 32'(cur_col), 32'd5);
    step(8'h0A, 2'd3, "scroll");
    chk("scroll_nwr", 32'(got_wr.size()), 32'd30);
    chk("scroll_row", 32'(cur_row), 32'd2);
    chk("scroll_lat", 32'(cyc), 32'd32);

    // Scroll with a host write burst to cells 0..2 while the copy is at idx 4
    for (int i = 0; i < 3; i++) hd[i] = 9'($urandom);
    model_apply(8'h0A, 2'd0);
    for (int i = 0; i < 3; i++) ref_mem[i] = hd[i];
    exp_lat = exp_lat + 3;
    send(8'h0A, 2'd0, 6);
    compare_all("scroll_host");

    // Form feed clears the whole screen
    step(8'h0C, 2'd0, "ff");
    chk("ff_nwr", 32'(got_wr.size()), 32'd30);
    chk("ff_last_data", 32'(last_d), 32'h020);

    // Random byte stream
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 19));
      if (k < 12) rb = 8'($urandom_range(32, 126));
      else if (k < 14) rb = 8'h0A;
      else if (k == 14) rb = 8'h0D;
      else if (k == 15) rb = 8'h08;
      else if (k == 16) rb = 8'h07;
      else if (k == 17) rb = 8'h0C;
      else if (k == 18) rb = 8'h7F;
      else rb = 8'($urandom_range(128, 255));
      rc = 2'($urandom);
      step(rb, rc, "rand");
    end

    // Reset in the middle of a scroll aborts it
    while (mr < R-1) step(8'h0A, 2'd0, "to_bottom");
    @(negedge clk);
    in_valid = 1'b1; in_byte = 8'h0A;
    @(negedge clk) in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1 chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_row", 32'(cur_row), 32'd0);
    chk("abort_col", 32'(cur_col), 32'd0);
    chk("abort_we", 32'(buf_we), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("abort_release_ready", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
